wb_commit_stage: RTL and testbench

- Parametrised writeback/commit stage for the N-issue LoongArch pipeline; sits after EX2/dcache and drives register-file write ports, CSR exception-update strobes and the pipeline flush.
- Commits up to LANES instructions per cycle in program order (lane 0 oldest).
- Resolves per-lane and dcache exceptions plus the external interrupt. Kills younger lanes behind a faulting lane.
- Stalls upstream while a memory lane waits on dcache, and suppresses writes for a programmable window after a flush.

---
 rtl/wb_commit_stage.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_wb_commit_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage.sv
// -----------------------------------------------------------------------------
// wb_commit_stage
//   Writeback/commit stage of the N-issue LoongArch pipeline. Takes the EX2
//   bundle (lane 0 oldest) plus the dcache response and, one cycle later,
//   drives the register-file write ports, the CSR exception-update strobes and
//   the pipeline flush.
//
//   - Lowest faulting lane wins; it and every younger lane are killed, older
//     lanes commit. An interrupt (with any lane valid) overrides lane faults
//     and kills the whole bundle.
//   - A load/store on MEM_LANE that is still waiting on dcache holds the
//     bundle (allowin = 0) unless an older-or-same lane already faults.
//   - After an exception commit, KILL_CYCLES further bundles are dropped.
//   - Lanes write only when in_we is set; on MEM_LANE with in_is_mem set, the
//     write uses dc_rd/dc_data. Writes to r0 are dropped.
//
// Ports
//   clk, aresetn        clock, synchronous active-low reset
//   in_*                per-lane bundle from EX2 (valid, pc, inst, rd, result,
//                       we, is_mem, exc, ecode, badv)
//   dc_*                dcache response for MEM_LANE
//   irq                 masked external interrupt
//   eentry, tlbrentry   exception entry vectors
//   allowin             stage accepts the presented bundle (combinational)
//   rf_we/waddr/wdata   registered register-file write ports
//   exc_*, era_out, badv_out, wen_badv, wen_vppn, tlb_refill
//                       registered CSR exception-update outputs
//   flush, flush_pc     pipeline flush and redirect target
//
// Build option
//   WB_DEBUG_EN         adds registered dbg_pc/dbg_inst/dbg_valid/dbg_wen/
//                       dbg_wnum/dbg_wdata trace outputs.
// -----------------------------------------------------------------------------
module wb_commit_stage #(
    parameter int LANES       = 2,
    parameter int DATA_W      = 32,
    parameter int RD_W        = 5,
    parameter int MEM_LANE    = 0,
    parameter int KILL_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_pc,
    input  logic [LANES*32-1:0]     in_inst,
    input  logic [LANES*RD_W-1:0]   in_rd,
    input  logic [LANES*DATA_W-1:0] in_result,
    input  logic [LANES-1:0]        in_we,
    input  logic [LANES-1:0]        in_is_mem,
    input  logic [LANES-1:0]        in_exc,
    input  logic [LANES*7-1:0]      in_ecode,
    input  logic [LANES*DATA_W-1:0] in_badv,
    input  logic                    dc_ready,
    input  logic [DATA_W-1:0]       dc_data,
    input  logic [RD_W-1:0]         dc_rd,
    input  logic [6:0]              dc_ecode,
    input  logic [DATA_W-1:0]       dc_badv,
    input  logic                    irq,
    input  logic [DATA_W-1:0]       eentry,
    input  logic [DATA_W-1:0]       tlbrentry,
    output logic                    allowin,
    output logic [LANES-1:0]        rf_we,
    output logic [LANES*RD_W-1:0]   rf_waddr,
    output logic [LANES*DATA_W-1:0] rf_wdata,
    output logic                    exc_flag,
    output logic [6:0]              exc_ecode,
    output logic                    exc_irq,
    output logic [DATA_W-1:0]       era_out,
    output logic [DATA_W-1:0]       badv_out,
    output logic                    wen_badv,
    output logic                    wen_vppn,
    output logic                    tlb_refill,
    output logic                    flush,
    output logic [DATA_W-1:0]       flush_pc
`ifdef WB_DEBUG_EN
    ,
    output logic [LANES*DATA_W-1:0] dbg_pc,
    output logic [LANES*32-1:0]     dbg_inst,
    output logic [LANES-1:0]        dbg_valid,
    output logic [LANES*4-1:0]      dbg_wen,
    output logic [LANES*RD_W-1:0]   dbg_wnum,
    output logic [LANES*DATA_W-1:0] dbg_wdata
`endif
);

    localparam logic [6:0] ECODE_PIL  = 7'h01;
    localparam logic [6:0] ECODE_PIS  = 7'h02;
    localparam logic [6:0] ECODE_PIF  = 7'h03;
    localparam logic [6:0] ECODE_PME  = 7'h04;
    localparam logic [6:0] ECODE_PPI  = 7'h07;
    localparam logic [6:0] ECODE_ADEF = 7'h08;
    localparam logic [6:0] ECODE_ALE  = 7'h09;
    localparam logic [6:0] ECODE_TLBR = 7'h3F;

    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_KILL} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              kill_cnt_q, kill_cnt_d;

    logic [LANES-1:0]        rf_we_q, rf_we_d;
    logic [LANES*RD_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [LANES*DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic                    exc_flag_q, exc_flag_d;
    logic [6:0]              exc_ecode_q, exc_ecode_d;
    logic                    exc_irq_q, exc_irq_d;
    logic [DATA_W-1:0]       era_q, era_d;
    logic [DATA_W-1:0]       badv_q, badv_d;
    logic                    wen_badv_q, wen_badv_d;
    logic                    wen_vppn_q, wen_vppn_d;
    logic                    tlb_refill_q, tlb_refill_d;

    logic [LANES-1:0]        lane_fault;
    logic [LANES-1:0]        lane_live;
    logic                    take_irq, early_exc, mem_wait, accept, exc_fire;
    logic                    sel_valid, sel_irq;
    int                      sel_idx;
    logic [6:0]              sel_ecode;
    logic [DATA_W-1:0]       sel_pc, sel_badv;
    logic [RD_W-1:0]         wr_rd;
    logic [DATA_W-1:0]       wr_data;

    // Fault detection, selection of the oldest fault, and the mem-wait hold.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        lane_fault = '0;
        early_exc  = 1'b0;
        sel_valid  = 1'b0;
        sel_irq    = 1'b0;
        sel_idx    = 0;
        sel_ecode  = '0;
        sel_pc     = '0;
        sel_badv   = '0;

        take_irq = irq & (|in_valid);

        for (int i = 0; i < LANES; i++) begin
            lane_fault[i] = in_valid[i] & (in_exc[i] |
                            ((i == MEM_LANE) & in_is_mem[i] & dc_ready & (dc_ecode != 7'd0)));
            if (i <= MEM_LANE) early_exc = early_exc | lane_fault[i];
        end
        early_exc = early_exc | take_irq;

        if (take_irq) begin
            sel_valid = 1'b1;
            sel_irq   = 1'b1;
            sel_pc    = in_pc[DATA_W-1:0];
        end else begin
            // Walk youngest to oldest so the oldest fault overwrites the rest.
            for (int i = LANES - 1; i >= 0; i--) begin
                if (lane_fault[i]) begin
                    sel_valid = 1'b1;
                    sel_idx   = i;
                    sel_pc    = in_pc[i*DATA_W +: DATA_W];
                    sel_ecode = in_exc[i] ? in_ecode[i*7 +: 7] : dc_ecode;
                    sel_badv  = in_exc[i] ? in_badv[i*DATA_W +: DATA_W] : dc_badv;
                end
            end
        end

        mem_wait = in_valid[MEM_LANE] & in_is_mem[MEM_LANE] & ~dc_ready & ~early_exc;
        accept   = (state_q != ST_KILL) & ~mem_wait;
        exc_fire = accept & sel_valid;
    end

    assign allowin = (state_q == ST_KILL) | ~mem_wait;

    // Register-file write ports: lanes older than the selected fault commit.
    always_comb begin
        lane_live  = '0;
        rf_we_d    = '0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        wr_rd      = '0;
        wr_data    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_live[i] = accept & in_valid[i] & ~(sel_valid & (i >= sel_idx));
            if ((i == MEM_LANE) && in_is_mem[i]) begin
                wr_rd   = dc_rd;
                wr_data = dc_data;
            end else begin
                wr_rd   = in_rd[i*RD_W +: RD_W];
                wr_data = in_result[i*DATA_W +: DATA_W];
            end
            if (lane_live[i] && in_we[i] && (wr_rd != '0)) begin
                rf_we_d[i]                    = 1'b1;
                rf_waddr_d[i*RD_W +: RD_W]     = wr_rd;
                rf_wdata_d[i*DATA_W +: DATA_W] = wr_data;
            end
        end
    end

    // Exception update strobes and the run/stall/kill sequencing.
    always_comb begin
        exc_flag_d   = exc_fire;
        exc_ecode_d  = exc_fire ? sel_ecode : '0;
        exc_irq_d    = exc_fire & sel_irq;
        era_d        = exc_fire ? sel_pc : '0;
        badv_d       = exc_fire ? sel_badv : '0;
        wen_badv_d   = exc_fire & (sel_ecode inside {ECODE_PIL, ECODE_PIS, ECODE_PIF, ECODE_PME,
                                                     ECODE_PPI, ECODE_ADEF, ECODE_ALE, ECODE_TLBR});
        wen_vppn_d   = exc_fire & (sel_ecode inside {ECODE_PIL, ECODE_PIS, ECODE_PIF, ECODE_PME,
                                                     ECODE_PPI, ECODE_TLBR});
        tlb_refill_d = exc_fire & (sel_ecode == ECODE_TLBR);

        state_d    = state_q;
        kill_cnt_d = kill_cnt_q;
        unique case (state_q)
            ST_RUN, ST_STALL: begin
                if (exc_fire) begin
                    state_d    = ST_KILL;
                    kill_cnt_d = 3'(KILL_CYCLES);
                end else if (mem_wait) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_KILL: begin
                // The counter covers exactly KILL_CYCLES dropped bundles.
                if (kill_cnt_q <= 3'd1) begin
                    state_d    = ST_RUN;
                    kill_cnt_d = '0;
                end else begin
                    kill_cnt_d = kill_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                kill_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge value; reset is synchronous, sampled only on the clock edge.
        if (!aresetn) begin
            state_q      <= ST_RUN;
            kill_cnt_q   <= '0;
            rf_we_q      <= '0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            exc_flag_q   <= 1'b0;
            exc_ecode_q  <= '0;
            exc_irq_q    <= 1'b0;
            era_q        <= '0;
            badv_q       <= '0;
            wen_badv_q   <= 1'b0;
            wen_vppn_q   <= 1'b0;
            tlb_refill_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_cnt_q   <= kill_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            exc_flag_q   <= exc_flag_d;
            exc_ecode_q  <= exc_ecode_d;
            exc_irq_q    <= exc_irq_d;
            era_q        <= era_d;
            badv_q       <= badv_d;
            wen_badv_q   <= wen_badv_d;
            wen_vppn_q   <= wen_vppn_d;
            tlb_refill_q <= tlb_refill_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign exc_flag   = exc_flag_q;
    assign exc_ecode  = exc_ecode_q;
    assign exc_irq    = exc_irq_q;
    assign era_out    = era_q;
    assign badv_out   = badv_q;
    assign wen_badv   = wen_badv_q;
    assign wen_vppn   = wen_vppn_q;
    assign tlb_refill = tlb_refill_q;
    assign flush      = exc_flag_q;
    assign flush_pc   = tlb_refill_q ? tlbrentry : eentry;

`ifdef WB_DEBUG_EN
    localparam logic [31:0] NOP_INST = 32'h0340_0000;

    logic [LANES*DATA_W-1:0] dbg_pc_q, dbg_pc_d;
    logic [LANES*32-1:0]     dbg_inst_q, dbg_inst_d;
    logic [LANES-1:0]        dbg_valid_q, dbg_valid_d;
    logic [LANES*4-1:0]      dbg_wen_q, dbg_wen_d;

    // Killed, stalled or flushed lanes trace as pc 0 with a NOP.
    always_comb begin
        dbg_pc_d    = '0;
        dbg_inst_d  = '0;
        dbg_valid_d = lane_live;
        dbg_wen_d   = '0;
        for (int i = 0; i < LANES; i++) begin
            dbg_inst_d[i*32 +: 32] = NOP_INST;
            if (lane_live[i]) begin
                dbg_pc_d[i*DATA_W +: DATA_W] = in_pc[i*DATA_W +: DATA_W];
                dbg_inst_d[i*32 +: 32]       = in_inst[i*32 +: 32];
            end
            dbg_wen_d[i*4 +: 4] = {3'b000, rf_we_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            dbg_pc_q    <= '0;
            dbg_inst_q  <= '0;
            dbg_valid_q <= '0;
            dbg_wen_q   <= '0;
        end else begin
            dbg_pc_q    <= dbg_pc_d;
            dbg_inst_q  <= dbg_inst_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_wen_q   <= dbg_wen_d;
        end
    end

    assign dbg_pc    = dbg_pc_q;
    assign dbg_inst  = dbg_inst_q;
    assign dbg_valid = dbg_valid_q;
    assign dbg_wen   = dbg_wen_q;
    assign dbg_wnum  = rf_waddr_q;
    assign dbg_wdata = rf_wdata_q;
`else
    // Instruction words only feed the trace outputs.
    logic unused_inputs;
    assign unused_inputs = ^{in_inst, in_is_mem};
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_commit_stage
//   Self-checking bench for wb_commit_stage (default parameters, LANES=2,
//   MEM_LANE=0, KILL_CYCLES=3). Directed bundles cover the basic scenarios;
//   a randomized phase compares every cycle against a behavioural model that
//   derives the expected commit from the architectural rules.
// -----------------------------------------------------------------------------
module tb_wb_commit_stage;

    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int MEM   = 0;
    localparam int KILLC = 3;

    logic                  clk = 1'b0;
    logic                  aresetn = 1'b0;
    logic [LANES-1:0]      in_valid, in_we, in_is_mem, in_exc;
    logic [LANES*DW-1:0]   in_pc, in_result, in_badv;
    logic [LANES*32-1:0]   in_inst;
    logic [LANES*RW-1:0]   in_rd;
    logic [LANES*7-1:0]    in_ecode;
    logic                  dc_ready, irq;
    logic [DW-1:0]         dc_data, dc_badv, eentry, tlbrentry;
    logic [RW-1:0]         dc_rd;
    logic [6:0]            dc_ecode;

    logic                  allowin, exc_flag, exc_irq, wen_badv, wen_vppn, tlb_refill, flush;
    logic [LANES-1:0]      rf_we;
    logic [LANES*RW-1:0]   rf_waddr;
    logic [LANES*DW-1:0]   rf_wdata;
    logic [6:0]            exc_ecode;
    logic [DW-1:0]         era_out, badv_out, flush_pc;

    int total = 0;
    int bad   = 0;
    int kill_left = 0;
    logic [6:0] ecodes [9];

    wb_commit_stage #(
        .LANES(LANES), .DATA_W(DW), .RD_W(RW), .MEM_LANE(MEM), .KILL_CYCLES(KILLC)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd),
        .in_result(in_result), .in_we(in_we), .in_is_mem(in_is_mem), .in_exc(in_exc),
        .in_ecode(in_ecode), .in_badv(in_badv),
        .dc_ready(dc_ready), .dc_data(dc_data), .dc_rd(dc_rd), .dc_ecode(dc_ecode),
        .dc_badv(dc_badv), .irq(irq), .eentry(eentry), .tlbrentry(tlbrentry),
        .allowin(allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .exc_flag(exc_flag), .exc_ecode(exc_ecode), .exc_irq(exc_irq),
        .era_out(era_out), .badv_out(badv_out), .wen_badv(wen_badv),
        .wen_vppn(wen_vppn), .tlb_refill(tlb_refill), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               allowin;
        logic [LANES-1:0]   we;
        logic [LANES*RW-1:0] waddr;
        logic [LANES*DW-1:0] wdata;
        logic               exc;
        logic [6:0]         ecode;
        logic               irq;
        logic [DW-1:0]      era;
        logic [DW-1:0]      badv;
        logic               wen_badv;
        logic               wen_vppn;
        logic               tlbr;
        logic [3:0]         next_kill;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected result of presenting the current inputs for one cycle.
    function automatic exp_t model();
        exp_t e;
        int f;
        logic [6:0] ec;
        logic [DW-1:0] bv;
        logic is_irq;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        e = '0;
        f = -1;
        ec = '0;
        bv = '0;
        is_irq = 1'b0;
        if (kill_left > 0) begin
            e.allowin = 1'b1;
            e.next_kill = 4'(kill_left - 1);
            return e;
        end
        if (irq && (in_valid != '0)) begin
            f = 0;
            is_irq = 1'b1;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (f < 0 && in_valid[i]) begin
                    if (in_exc[i]) begin
                        f  = i;
                        ec = in_ecode[i*7 +: 7];
                        bv = in_badv[i*DW +: DW];
                    end else if (i == MEM && in_is_mem[i] && dc_ready && dc_ecode != 0) begin
                        f  = i;
                        ec = dc_ecode;
                        bv = dc_badv;
                    end
                end
            end
        end
        if (in_valid[MEM] && in_is_mem[MEM] && !dc_ready && !(f >= 0 && f <= MEM)) begin
            e.allowin = 1'b0;
            return e;
        end
        e.allowin = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (in_valid[i] && in_we[i] && (f < 0 || i < f)) begin
                if (i == MEM && in_is_mem[i]) begin
                    rd = dc_rd;
                    data = dc_data;
                end else begin
                    rd = in_rd[i*RW +: RW];
                    data = in_result[i*DW +: DW];
                end
                if (rd != 0) begin
                    e.we[i] = 1'b1;
                    e.waddr[i*RW +: RW] = rd;
                    e.wdata[i*DW +: DW] = data;
                end
            end
        end
        if (f >= 0) begin
            e.exc      = 1'b1;
            e.ecode    = ec;
            e.irq      = is_irq;
            e.era      = in_pc[f*DW +: DW];
            e.badv     = bv;
            e.wen_badv = ec inside {7'h01, 7'h02, 7'h03, 7'h04, 7'h07, 7'h08, 7'h09, 7'h3F};
            e.wen_vppn = ec inside {7'h01, 7'h02, 7'h03, 7'h04, 7'h07, 7'h3F};
            e.tlbr     = (ec == 7'h3F);
            e.next_kill = 4'(KILLC);
        end
        return e;
    endfunction

    task automatic clear_inputs();
        in_valid = '0; in_we = '0; in_is_mem = '0; in_exc = '0;
        in_pc = '0; in_result = '0; in_badv = '0; in_inst = '0;
        in_rd = '0; in_ecode = '0;
        dc_ready = 1'b0; dc_data = '0; dc_rd = '0; dc_ecode = '0; dc_badv = '0;
        irq = 1'b0;
        eentry = 32'h1C00_8000;
        tlbrentry = 32'h0000_8000;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [DW-1:0] pc,
                            input logic [RW-1:0] rd, input logic [DW-1:0] res,
                            input logic we, input logic mem, input logic exc,
                            input logic [6:0] ec, input logic [DW-1:0] bv);
        in_valid[i] = v;
        in_pc[i*DW +: DW] = pc;
        in_inst[i*32 +: 32] = $urandom();
        in_rd[i*RW +: RW] = rd;
        in_result[i*DW +: DW] = res;
        in_we[i] = we;
        in_is_mem[i] = mem;
        in_exc[i] = exc;
        in_ecode[i*7 +: 7] = ec;
        in_badv[i*DW +: DW] = bv;
    endtask

    task automatic run_cycle(input string tag);
        exp_t e;
        #1;
        e = model();
        check({tag, ".allowin"}, 64'(allowin), 64'(e.allowin));
        @(posedge clk);
        #1;
        check({tag, ".rf_we"}, 64'(rf_we), 64'(e.we));
        for (int i = 0; i < LANES; i++) begin
            if (e.we[i]) begin
                check({tag, ".waddr"}, 64'(rf_waddr[i*RW +: RW]), 64'(e.waddr[i*RW +: RW]));
                check({tag, ".wdata"}, 64'(rf_wdata[i*DW +: DW]), 64'(e.wdata[i*DW +: DW]));
            end
        end
        check({tag, ".exc_flag"}, 64'(exc_flag), 64'(e.exc));
        check({tag, ".flush"}, 64'(flush), 64'(e.exc));
        check({tag, ".wen_badv"}, 64'(wen_badv), 64'(e.wen_badv));
        check({tag, ".wen_vppn"}, 64'(wen_vppn), 64'(e.wen_vppn));
        if (e.exc) begin
            check({tag, ".ecode"}, 64'(exc_ecode), 64'(e.ecode));
            check({tag, ".exc_irq"}, 64'(exc_irq), 64'(e.irq));
            check({tag, ".era"}, 64'(era_out), 64'(e.era));
            if (!e.irq) check({tag, ".badv"}, 64'(badv_out), 64'(e.badv));
            check({tag, ".tlb_refill"}, 64'(tlb_refill), 64'(e.tlbr));
            check({tag, ".flush_pc"}, 64'(flush_pc), 64'(e.tlbr ? tlbrentry : eentry));
        end
        kill_left = int'(e.next_kill);
    endtask

    task automatic do_reset(input string tag);
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".rf_we"}, 64'(rf_we), 64'd0);
        check({tag, ".rf_waddr"}, 64'(rf_waddr), 64'd0);
        check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'd0);
        check({tag, ".exc_flag"}, 64'(exc_flag), 64'd0);
        check({tag, ".exc_ecode"}, 64'(exc_ecode), 64'd0);
        check({tag, ".exc_irq"}, 64'(exc_irq), 64'd0);
        check({tag, ".era"}, 64'(era_out), 64'd0);
        check({tag, ".badv"}, 64'(badv_out), 64'd0);
        check({tag, ".wen_badv"}, 64'(wen_badv), 64'd0);
        check({tag, ".wen_vppn"}, 64'(wen_vppn), 64'd0);
        check({tag, ".tlb_refill"}, 64'(tlb_refill), 64'd0);
        check({tag, ".flush"}, 64'(flush), 64'd0);
        aresetn = 1'b1;
        kill_left = 0;
    endtask

    task automatic alu_bundle();
        clear_inputs();
        set_lane(0, 1'b1, 32'h1C00_0200, 5'd10, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 7'h00, '0);
        set_lane(1, 1'b1, 32'h1C00_0204, 5'd11, 32'hBBBB_0002, 1'b1, 1'b0, 1'b0, 7'h00, '0);
    endtask

    initial begin
        ecodes = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h07, 7'h08, 7'h09, 7'h3F, 7'h0B};
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Two ALU lanes commit together.
        clear_inputs();
        set_lane(0, 1'b1, 32'h1C00_0000, 5'd3, 32'h11, 1'b1, 1'b0, 1'b0, 7'h00, '0);
        set_lane(1, 1'b1, 32'h1C00_0004, 5'd4, 32'h22, 1'b1, 1'b0, 1'b0, 7'h00, '0);
        run_cycle("alu2");

        // Load on lane 0 waits four cycles for dcache.
        clear_inputs();
        set_lane(0, 1'b1, 32'h1C00_0010, 5'd9, 32'h0, 1'b1, 1'b1, 1'b0, 7'h00, '0);
        repeat (4) run_cycle("ld_wait");
        dc_ready = 1'b1;
        dc_data  = 32'hDEAD_BEEF;
        dc_rd    = 5'd7;
        run_cycle("ld_done");

        // ALE on lane 1: lane 0 commits, then three bundles are dropped.
        clear_inputs();
        set_lane(0, 1'b1, 32'h1C00_0100, 5'd5, 32'h55, 1'b1, 1'b0, 1'b0, 7'h00, '0);
        set_lane(1, 1'b1, 32'h1C00_0104, 5'd6, 32'h66, 1'b1, 1'b0, 1'b1, 7'h09, 32'h1003);
        run_cycle("ale");
        alu_bundle();
        repeat (3) run_cycle("kill");
        run_cycle("post_kill");

        // TLB refill on lane 0 redirects to tlbrentry.
        clear_inputs();
        set_lane(0, 1'b1, 32'h1C00_0300, 5'd5, 32'h1, 1'b1, 1'b0, 1'b1, 7'h3F, 32'h0040_2000);
        set_lane(1, 1'b1, 32'h1C00_0304, 5'd6, 32'h2, 1'b1, 1'b0, 1'b0, 7'h00, '0);
        run_cycle("tlbr");
        clear_inputs();
        repeat (3) run_cycle("idle");

        // Interrupt overrides a lane-1 exception and kills both lanes.
        clear_inputs();
        set_lane(0, 1'b1, 32'h1C00_0400, 5'd5, 32'h1, 1'b1, 1'b0, 1'b0, 7'h00, '0);
        set_lane(1, 1'b1, 32'h1C00_0404, 5'd6, 32'h2, 1'b1, 1'b0, 1'b1, 7'h08, 32'h77);
        irq = 1'b1;
        run_cycle("irq");
        clear_inputs();
        repeat (3) run_cycle("idle");

        // Reset in the middle of the kill window.
        clear_inputs();
        set_lane(0, 1'b1, 32'h1C00_0500, 5'd5, 32'h1, 1'b1, 1'b0, 1'b1, 7'h08, 32'h1C00_0500);
        run_cycle("adef");
        alu_bundle();
        run_cycle("kill");
        do_reset("reset_kill");
        alu_bundle();
        run_cycle("after_reset");

        // Randomized bundles.
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            for (int i = 0; i < LANES; i++) begin
                set_lane(i, ($urandom() % 5) != 0,
                         32'h1C00_0000 + 32'($urandom_range(0, 1023) * 4),
                         5'($urandom_range(0, 7)), $urandom(),
                         ($urandom() % 4) != 0, ($urandom() % 3) == 0,
                         ($urandom() % 16) == 0, ecodes[$urandom_range(0, 8)], $urandom());
            end
            irq      = ($urandom() % 25) == 0;
            dc_ready = ($urandom() % 5) < 3;
            dc_data  = $urandom();
            dc_rd    = 5'($urandom_range(0, 7));
            dc_ecode = (($urandom() % 10) == 0) ? ecodes[$urandom_range(0, 8)] : 7'h00;
            dc_badv  = $urandom();
            run_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
